// File: rtl/dual_stream_arith_pkg.sv
// Shared types and helpers for the dual-stream pixel arithmetic unit.
package dual_stream_arith_pkg;

    typedef enum logic [1:0] {
        MODE_SUB = 2'd0,
        MODE_ABS = 2'd1,
        MODE_ADD = 2'd2,
        MODE_AVG = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    function automatic int frame_size(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/img_sync_fifo.sv
// Single-clock alignment FIFO: push/pop/flush with registered read data.
// A push into a full FIFO is discarded; flush empties it in one cycle.
module img_sync_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(P_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(P_DEPTH);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [P_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign rd_data = rd_data_q;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/dual_stream_image_arith.sv
// Aligns master/slave pixel streams, combines each pair arithmetically and
// re-frames the result with a pixel-counted v_sync and a sticky error flag.
module dual_stream_image_arith
    import dual_stream_arith_pkg::*;
#(
    parameter int P_INPUT_DATA_WIDTH  = 8,
    parameter int P_OUTPUT_DATA_WIDTH = 8,
    parameter int P_IMG_WIDTH         = 256,
    parameter int P_IMG_HEIGHT        = 256,
    parameter int P_SKEW_DEPTH        = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_h_sync_m,
    input  logic                           i_v_sync_m,
    input  logic [P_INPUT_DATA_WIDTH-1:0]  i_data_m,
    input  logic                           i_h_sync_s,
    input  logic                           i_v_sync_s,
    input  logic [P_INPUT_DATA_WIDTH-1:0]  i_data_s,
    input  logic [1:0]                     i_mode,
    input  logic                           i_thr_en,
    input  logic [P_OUTPUT_DATA_WIDTH-1:0] i_thr,
    input  logic                           i_err_clr,
    output logic                           o_v_sync,
    output logic                           o_h_sync,
    output logic [P_OUTPUT_DATA_WIDTH-1:0] o_res_data,
    output logic                           o_err
);
    localparam int IW       = P_INPUT_DATA_WIDTH;
    localparam int OW       = P_OUTPUT_DATA_WIDTH;
    localparam int FRAME_PX = frame_size(P_IMG_WIDTH, P_IMG_HEIGHT);
    localparam int CNT_W    = $clog2(FRAME_PX + 1);
    localparam int CW       = (IW + 1 > OW) ? IW + 1 : OW;
    localparam logic [CW-1:0]    OMAX      = CW'({OW{1'b1}});
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_PX);

    logic          h_m_q, h_m_d, v_m_q, v_m_d, h_s_q, h_s_d, v_s_q, v_s_d;
    logic [IW-1:0] data_m_q, data_m_d, data_s_q, data_s_d;
    logic [1:0]    mode_in_q, mode_in_d;
    logic          thr_en_in_q, thr_en_in_d, err_clr_q, err_clr_d;
    logic [OW-1:0] thr_in_q, thr_in_d;

    mode_e         cfg_mode_q, cfg_mode_d;
    logic          cfg_thr_en_q, cfg_thr_en_d;
    logic [OW-1:0] cfg_thr_q, cfg_thr_d;

    logic          push_m, push_s, pop, flush_m, flush_s;
    logic          m_full, m_empty, s_full, s_empty;
    logic [IW-1:0] m_rd, s_rd;

    logic          rd_valid_q, rd_valid_d, res_valid_q, res_valid_d;
    logic [OW-1:0] res_q, res_d;
    logic          out_h_q, out_h_d;
    logic [OW-1:0] out_data_q, out_data_d;
    frame_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [IW:0]   m_ext, s_ext, sum, raw;
    logic [CW-1:0] raw_c, clamped;
    logic          short_frame, err_event;

    assign push_m  = h_m_q && v_m_q;
    assign push_s  = h_s_q && v_s_q;
    assign pop     = !m_empty && !s_empty;
    // One stream ended with pixels its partner never delivered: discard them.
    assign flush_m = !v_m_q && !v_s_q && !m_empty && s_empty;
    assign flush_s = !v_m_q && !v_s_q && m_empty && !s_empty;

    img_sync_fifo #(.P_WIDTH(IW), .P_DEPTH(P_SKEW_DEPTH)) u_fifo_m (
        .clk(i_clk), .rst(i_rst), .push(push_m), .push_data(data_m_q),
        .pop(pop), .flush(flush_m), .rd_data(m_rd), .full(m_full), .empty(m_empty)
    );

    img_sync_fifo #(.P_WIDTH(IW), .P_DEPTH(P_SKEW_DEPTH)) u_fifo_s (
        .clk(i_clk), .rst(i_rst), .push(push_s), .push_data(data_s_q),
        .pop(pop), .flush(flush_s), .rd_data(s_rd), .full(s_full), .empty(s_empty)
    );

    always_comb begin
        h_m_d       = i_h_sync_m;
        v_m_d       = i_v_sync_m;
        data_m_d    = i_data_m;
        h_s_d       = i_h_sync_s;
        v_s_d       = i_v_sync_s;
        data_s_d    = i_data_s;
        mode_in_d   = i_mode;
        thr_en_in_d = i_thr_en;
        thr_in_d    = i_thr;
        err_clr_d   = i_err_clr;

        cfg_mode_d   = cfg_mode_q;
        cfg_thr_en_d = cfg_thr_en_q;
        cfg_thr_d    = cfg_thr_q;
        if (state_q == ST_IDLE && cnt_q == '0) begin
            cfg_mode_d   = mode_e'(mode_in_q);
            cfg_thr_en_d = thr_en_in_q;
            cfg_thr_d    = thr_in_q;
        end

        m_ext = {1'b0, m_rd};
        s_ext = {1'b0, s_rd};
        sum   = m_ext + s_ext;
        case (cfg_mode_q)
            MODE_SUB: raw = (m_ext >= s_ext) ? m_ext - s_ext : '0;
            MODE_ABS: raw = (m_ext >= s_ext) ? m_ext - s_ext : s_ext - m_ext;
            MODE_ADD: raw = sum;
            default:  raw = sum >> 1;
        endcase
        raw_c   = CW'(raw);
        clamped = (raw_c > OMAX) ? OMAX : raw_c;
        res_d   = clamped[OW-1:0];
        if (cfg_thr_en_q) res_d = (res_d >= cfg_thr_q) ? '1 : '0;

        rd_valid_d  = pop;
        res_valid_d = rd_valid_q;
        out_h_d     = res_valid_q;
        out_data_d  = res_valid_q ? res_q : '0;

        // Streams gone quiet and nothing left in flight, yet the frame is incomplete.
        short_frame = (state_q == ST_ACTIVE) && !v_m_q && !v_s_q && m_empty && s_empty
                      && !rd_valid_q && !res_valid_q && (cnt_q != FRAME_END);

        state_d = state_q;
        cnt_d   = cnt_q;
        if (res_valid_q) begin
            state_d = ST_ACTIVE;
            cnt_d   = (cnt_q == FRAME_END) ? CNT_W'(1) : cnt_q + 1'b1;
        end else if (state_q == ST_ACTIVE && (cnt_q == FRAME_END || short_frame)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        err_event = (push_m && m_full) || (push_s && s_full) || flush_m || flush_s || short_frame;
        err_d     = err_event ? 1'b1 : (err_clr_q ? 1'b0 : err_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_m_q        <= 1'b0;
            v_m_q        <= 1'b0;
            data_m_q     <= '0;
            h_s_q        <= 1'b0;
            v_s_q        <= 1'b0;
            data_s_q     <= '0;
            mode_in_q    <= '0;
            thr_en_in_q  <= 1'b0;
            thr_in_q     <= '0;
            err_clr_q    <= 1'b0;
            cfg_mode_q   <= MODE_SUB;
            cfg_thr_en_q <= 1'b0;
            cfg_thr_q    <= '0;
            rd_valid_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
            out_h_q      <= 1'b0;
            out_data_q   <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            h_m_q        <= h_m_d;
            v_m_q        <= v_m_d;
            data_m_q     <= data_m_d;
            h_s_q        <= h_s_d;
            v_s_q        <= v_s_d;
            data_s_q     <= data_s_d;
            mode_in_q    <= mode_in_d;
            thr_en_in_q  <= thr_en_in_d;
            thr_in_q     <= thr_in_d;
            err_clr_q    <= err_clr_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_thr_en_q <= cfg_thr_en_d;
            cfg_thr_q    <= cfg_thr_d;
            rd_valid_q   <= rd_valid_d;
            res_valid_q  <= res_valid_d;
            res_q        <= res_d;
            out_h_q      <= out_h_d;
            out_data_q   <= out_data_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign o_v_sync   = (state_q == ST_ACTIVE);
    assign o_h_sync   = out_h_q;
    assign o_res_data = out_data_q;
    assign o_err      = err_q;

endmodule

// File: doc/dual_stream_image_arith.md
Name: dual_stream_image_arith

Overview:
- Two-stream pixel arithmetic unit for the IR pipeline: master (m) and slave (s) video streams, each with h_sync/v_sync framing.
- Each stream lands in a small alignment FIFO, which absorbs up to P_SKEW_DEPTH pixels of skew between the sensors.
- Aligned pixel pairs go through a selectable operation (sat-sub, abs-diff, sat-add, average), then optional binarisation.
- Output is a re-framed stream with a pixel-counted v_sync and a sticky error flag. Sits between sensor capture and the enhancement chain.

Parameters:
- P_INPUT_DATA_WIDTH, 8, input pixel width.
- P_OUTPUT_DATA_WIDTH, 8, output pixel width (>=1). Results saturate to 2^P_OUTPUT_DATA_WIDTH-1.
- P_IMG_WIDTH, 256, pixels per line.
- P_IMG_HEIGHT, 256, lines per frame.
- P_SKEW_DEPTH, 16, per-stream alignment FIFO depth. Must be a power of two and >=4.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_h_sync_m, in, 1, master pixel valid within line.
- i_v_sync_m, in, 1, master frame active.
- i_data_m, in, P_INPUT_DATA_WIDTH, master pixel.
- i_h_sync_s, in, 1, slave pixel valid within line.
- i_v_sync_s, in, 1, slave frame active.
- i_data_s, in, P_INPUT_DATA_WIDTH, slave pixel.
- i_mode, in, 2, operation select: 0 sat-sub, 1 abs-diff, 2 sat-add, 3 average.
- i_thr_en, in, 1, binarisation enable.
- i_thr, in, P_OUTPUT_DATA_WIDTH, binarisation threshold.
- i_err_clr, in, 1, clears o_err.
- o_v_sync, out, 1, output frame active.
- o_h_sync, out, 1, output pixel valid.
- o_res_data, out, P_OUTPUT_DATA_WIDTH, result pixel.
- o_err, out, 1, sticky: FIFO overflow, stream mismatch, or short frame.

Behaviour:
- Clocking/reset: one clock, i_clk. Reset is asynchronous and active-high on i_rst. All state clears on reset.
- Reset values: o_v_sync=0, o_h_sync=0, o_res_data=0, o_err=0, both FIFOs empty, pixel counter=0, latched mode/threshold config=0.
- Input stage: all inputs are registered once.
- FIFO write: a registered pixel is written into its own stream's FIFO when that stream's h_sync && v_sync are both high.
- FIFO overflow: a write to a full FIFO drops the pixel and sets o_err. The FIFO contents are unchanged.
- Pop: both FIFOs pop together in any cycle where both are non-empty. Read data is registered.
- Arithmetic stage: computed at P_INPUT_DATA_WIDTH+1 bits, unsigned.
  - sat-sub: max(m-s, 0).
  - abs-diff: |m-s|.
  - sat-add: m+s.
  - average: (m+s)>>1, truncating.
  - The result is then clamped to the P_OUTPUT_DATA_WIDTH maximum.
- Binarisation: if the latched threshold enable is set, the result becomes all-ones when result >= latched threshold, otherwise 0.
- Output register: o_h_sync=1 for exactly one cycle per popped pair. o_res_data=0 whenever o_h_sync=0.
- Latency: with aligned inputs, a pixel present at the inputs at edge k appears on the outputs after edge k+4 (4 cycles). Skew adds the lag of the later stream.
- Config latch: i_mode, i_thr_en and i_thr are latched only when the output frame is idle (o_v_sync=0 and pixel counter=0). They are stable for the whole frame; mid-frame changes are ignored.
- Output framing states: IDLE -> ACTIVE -> IDLE.
  - IDLE->ACTIVE: o_v_sync rises together with the first o_h_sync of a frame.
  - Pixel counter: counts output pixels 0..W*H-1.
  - ACTIVE->IDLE: o_v_sync falls on the edge after pixel W*H-1 is output; the counter returns to 0.
- Mismatch: both registered v_sync are low and exactly one FIFO is non-empty. That FIFO is flushed in one cycle and o_err is set.
- Short frame: in ACTIVE, both registered v_sync are low, both FIFOs are empty, the pipeline is empty, and the counter is not at W*H. Then o_v_sync falls, the counter resets and o_err is set.
- Long frame: pixel pairs arriving after W*H start a new output frame (IDLE->ACTIVE again). No error is flagged.
- Error flag: o_err is sticky. i_err_clr clears it. A simultaneous new error event wins, and o_err stays 1.
- Reset mid-frame: aborts immediately and all outputs go to their reset values.

Decomposition:
- Package dual_stream_arith_pkg: mode encodings (MODE_SUB=0, MODE_ABS=1, MODE_ADD=2, MODE_AVG=3) and the W*H frame-size constant function.
- One sub-module, img_sync_fifo: single-clock FIFO with parameterised width/depth, push/pop/flush, full/empty, registered read data.
- The block instantiates img_sync_fifo twice.

Test Plan:
- Aligned streams, mode 0, m=200 s=50 -> 150; m=50 s=200 -> 0. First pixel out 4 cycles after input. o_v_sync high for exactly W*H pixels.
- Slave lagging master by 10 cycles, mode 1, m=30 s=100 -> 70. Output pixel order preserved, no o_err, output lag = 14 cycles.
- Mode 2 with m=200 s=100, then mode 3 with m=255 s=254, P_OUTPUT_DATA_WIDTH=8 -> 255 then 254. Change i_mode mid-frame -> no effect until the next frame.
- i_thr_en=1, i_thr=128, mode 0: m=200 s=50 -> 255; m=100 s=50 -> 0.
- Slave held off for P_SKEW_DEPTH+1 master pixels -> o_err=1 and one pixel dropped. Pulse i_err_clr with no new fault -> o_err=0.
- Master frame 5 pixels short -> o_v_sync falls after the drain, o_err=1. Assert i_rst mid-frame -> all outputs 0 asynchronously.
